ysyx_22040088_exu_ctrl: RTL

//  Multi-cycle sequencer for the NPC execute datapath (ALU, branch/next-PC logic, imm extension).

---
 rtl/ysyx_22040088_exu_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/ysyx_22040088_exu_ctrl.sv
// Multi-cycle sequencer for the NPC execute stage: accepts one decoded instruction,
// drives mul/div and LSU handshakes, then commits rd and PC in a single write-back cycle.
module ysyx_22040088_exu_ctrl #(
  parameter int MEM_TO = 16,
  parameter int CNT_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic             is_muldiv,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_ebreak,
  input  logic             rd_wen,
  output logic             md_start,
  input  logic             md_done,
  output logic             mem_req,
  output logic             mem_wen,
  input  logic             mem_ack,
  output logic             rf_wen,
  output logic             pc_wen,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             err
);

  localparam int TO_W = $clog2(MEM_TO);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MD_WAIT, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t state, state_nxt;

  logic            lat_md, lat_ld, lat_st, lat_eb, lat_rdw;
  logic [TO_W-1:0] to_cnt;
  logic            hs;
  logic            retire;

  assign hs = inst_valid & inst_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (hs) state_nxt = S_EXEC;
      S_EXEC: begin
        if (lat_eb)                state_nxt = S_HALT;
        else if (lat_md)           state_nxt = S_MD_WAIT;
        else if (lat_ld || lat_st) state_nxt = S_MEM;
        else                       state_nxt = S_WB;
      end
      S_MD_WAIT: if (md_done) state_nxt = S_WB;
      // An ack in the limit cycle still completes the access.
      S_MEM: begin
        if (mem_ack)                state_nxt = S_WB;
        else if (to_cnt == TO_LAST) state_nxt = S_ERR;
      end
      S_WB:      state_nxt = S_IDLE;
      S_HALT:    state_nxt = S_HALT;
      S_ERR:     state_nxt = S_ERR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inst_ready = rst & (state == S_IDLE);
    md_start   = (state == S_EXEC) & ~lat_eb & lat_md;
    mem_req    = (state == S_MEM);
    mem_wen    = (state == S_MEM) & lat_st & ~lat_ld;
    rf_wen     = (state == S_WB) & lat_rdw & ~lat_st;
    pc_wen     = (state == S_WB);
    halted     = (state == S_HALT);
    err        = (state == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_md  <= 1'b0;
      lat_ld  <= 1'b0;
      lat_st  <= 1'b0;
      lat_eb  <= 1'b0;
      lat_rdw <= 1'b0;
    end else if (hs) begin
      lat_md  <= is_muldiv;
      lat_ld  <= is_load;
      lat_st  <= is_store;
      lat_eb  <= is_ebreak;
      lat_rdw <= rd_wen;
    end
  end

  // Counter restarts from zero on every entry into MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 to_cnt <= '0;
    else if (state == S_MEM)  to_cnt <= to_cnt + TO_W'(1);
    else                      to_cnt <= '0;
  end

  assign retire = (state == S_WB) | ((state == S_EXEC) & lat_eb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

endmodule
